imem_load_controller: RTL
=========================

// Module: imem_load_controller
// PURPOSE
//  Sequences program loading into the 128x32 instruction memory: accepts words on a valid/ready
//  stream and writes them to consecutive addresses from 0. Holds the CPU (cpu_hold) until the
//  load completes, then muxes the memory read port over to the CPU fetch address.
//  Sits between the host/test loader and instruction_memory's write and read address ports.
// PARAMETERS
//  ADDR_W  7    instruction memory address width
//  DATA_W  32   instruction word width
//  DEPTH   128  number of words; last writable address = DEPTH-1
// PORTS
//  clk              in   1       single clock, rising edge
//  rst_all          in   1       synchronous active-low reset
//  start            in   1       begin a load; sampled only in IDLE or DONE
//  in_valid         in   1       host word valid
//  in_data          in   DATA_W  host instruction word
//  in_last          in   1       qualifies in_data as final word of program
//  in_ready         out  1       controller accepts word this cycle
//  pc_addr          in   ADDR_W  CPU fetch address
//  imem_we          out  1       instruction memory write enable
//  imem_write_addr  out  ADDR_W  instruction memory write address
//  imem_write_data  out  DATA_W  instruction memory write data
//  imem_read_addr   out  ADDR_W  instruction memory read address
//  imem_read_data   in   DATA_W  instruction memory read data (combinational read)
//  cpu_hold         out  1       1 = CPU must stall/remain in reset
//  load_done        out  1       1 = program loaded, CPU running
//  word_count       out  ADDR_W+1  words written in current/last load
//  error            out  1       sticky load fault (overflow / verify mismatch)
// BEHAVIOUR
//  - Reset (rst_all=0 at posedge): state=IDLE, addr=0, word_count=0, cpu_hold=1, load_done=0,
//    error=0, in_ready=0. Reset mid-load abandons load; the memory is cleared by its own rst_all.
//  - FSM: IDLE -start-> LOAD; LOAD -accept last word-> DONE (or VERIFY with VERIFY_EN);
//    DONE -start-> LOAD. start ignored in LOAD/VERIFY.
//  - Entering LOAD: addr=0, word_count=0, error=0, cpu_hold=1, load_done=0.
//  - LOAD: in_ready=1. Accept = in_valid & in_ready. imem_we = accept (combinational),
//    imem_write_addr = addr, imem_write_data = in_data; write lands at the same edge.
//    On accept: addr+1, word_count+1. No zero-latency bubble: back-to-back words, one per cycle.
//  - Last word: accept with in_last=1, or accept at addr==DEPTH-1. If addr==DEPTH-1 and
//    in_last=0 -> error=1 (overflow), load terminates; further in_valid ignored (in_ready=0).
//  - addr never wraps; word_count max = DEPTH (8 bits for default).
//  - DONE: cpu_hold=0, load_done=1, in_ready=0, imem_we=0; outputs registered, change one cycle
//    after the final accept (or after VERIFY finishes).
//  - imem_read_addr = pc_addr whenever state!=VERIFY.
//  - imem_we is 0 in every state but LOAD; never asserted during reset.
// CONFIGURATION
//  VERIFY_EN defined: after LOAD, state VERIFY reads addresses 0..word_count-1, one per cycle,
//    imem_read_addr = verify address; XOR of imem_read_data compared with XOR of all accepted
//    in_data. Mismatch -> error=1. DONE entered the cycle after the last read (latency =
//    word_count cycles). cpu_hold stays 1 throughout VERIFY.
//  VERIFY_EN undefined: no VERIFY state, no XOR registers; LOAD goes directly to DONE.
// TESTING
//  1 Reset: hold rst_all=0 2 cycles -> cpu_hold=1, load_done=0, in_ready=0, imem_we=0, error=0.
//  2 start, stream 4 words 0xE3A00001..0xE3A00004, last on 4th -> writes addr 0..3 on 4
//    consecutive cycles, word_count=4, load_done=1 and cpu_hold=0 (+4 cycles with VERIFY_EN).
//  3 Gapped stream (in_valid low 2 cycles between words) -> no write on idle cycles,
//    addresses stay contiguous, final contents match input.
//  4 Stream 129 words with in_last never set -> 128 writes (addr 0..127), error=1,
//    129th word not accepted (in_ready=0), addr never wraps to 0.
//  5 Assert rst_all=0 after 2 of 5 words -> IDLE, cpu_hold=1, word_count=0;
//    restart load completes normally.
//  6 VERIFY_EN, force a bad imem_read_data at addr 1 during VERIFY -> error=1 after DONE.

Source files
------------

// File: rtl/imem_load_controller.sv
// Streams a program into the 128x32 instruction memory and releases the CPU once loading is done.
// Optional `VERIFY_EN: XOR read-back check of the loaded image before the CPU is released.
module imem_load_controller #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_write_addr,
    output logic [DATA_W-1:0] imem_write_data,
    output logic [ADDR_W-1:0] imem_read_addr,
    input  logic [DATA_W-1:0] imem_read_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

`ifdef VERIFY_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                err_q, err_d;
    logic                accept;
`ifdef VERIFY_EN
    logic [DATA_W-1:0]   xor_in_q, xor_in_d;
    logic [DATA_W-1:0]   xor_rd_q, xor_rd_d;
`else
    logic                unused_rd;
    assign unused_rd = ^imem_read_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_all) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wc_q     <= '0;
            err_q    <= 1'b0;
`ifdef VERIFY_EN
            xor_in_q <= '0;
            xor_rd_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            err_q    <= err_d;
`ifdef VERIFY_EN
            xor_in_q <= xor_in_d;
            xor_rd_q <= xor_rd_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wc_d           = wc_q;
        err_d          = err_q;
        in_ready       = 1'b0;
        accept         = 1'b0;
        imem_read_addr = pc_addr;
`ifdef VERIFY_EN
        xor_in_d       = xor_in_q;
        xor_rd_d       = xor_rd_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    addr_d   = '0;
                    wc_d     = '0;
                    err_d    = 1'b0;
`ifdef VERIFY_EN
                    xor_in_d = '0;
                    xor_rd_d = '0;
`endif
                end
            end
            S_LOAD: begin
                // Gated by reset so no write can land on a reset edge
                in_ready = rst_all;
                accept   = in_valid & rst_all;
                if (accept) begin
                    wc_d = wc_q + 1'b1;
`ifdef VERIFY_EN
                    xor_in_d = xor_in_q ^ in_data;
`endif
                    if (in_last || addr_q == LAST_ADDR) begin
                        err_d = err_q | ~in_last;
`ifdef VERIFY_EN
                        state_d = S_VERIFY;
                        addr_d  = '0;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef VERIFY_EN
            S_VERIFY: begin
                imem_read_addr = addr_q;
                xor_rd_d       = xor_rd_q ^ imem_read_data;
                if ({1'b0, addr_q} + 1'b1 == wc_q) begin
                    state_d = S_DONE;
                    if (xor_rd_d != xor_in_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_we         = accept;
    assign imem_write_addr = addr_q;
    assign imem_write_data = in_data;
    assign cpu_hold        = (state_q != S_DONE);
    assign load_done       = (state_q == S_DONE);
    assign word_count      = wc_q;
    assign error           = err_q;

endmodule
